// File: rtl/pipeline_stall_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl_pkg
// Brief  : Shared state encoding and default multiply latency for the stall controller.
// Rev    : 1.0
// ============================================================================
package pipe_ctrl_pkg;

    typedef logic [0:0] state_t;

    localparam state_t c_RUN       = 1'b0;
    localparam state_t c_MUL_WAIT  = 1'b1;

    localparam int     c_DEF_MUL_LAT = 4;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_stall_controller_if.sv
`default_nettype none
// ============================================================================
// Module : pipeline_stall_controller_if
// Brief  : Hazard inputs from ID/EX and pipeline-control outputs of the stall controller.
// Rev    : 1.0
// ============================================================================
interface pipeline_stall_controller_if #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
);
    logic [REG_ADDR_W-1:0]  ID_Rs;
    logic [REG_ADDR_W-1:0]  ID_Rt;
    logic                   ID_UsesRs;
    logic                   ID_UsesRt;
    logic                   ID_IsMul;
    logic                   EX_MemRead;
    logic [REG_ADDR_W-1:0]  EX_Rd;
    logic                   EX_BranchTaken;

    logic                   PCWrite;
    logic                   IFIDWrite;
    logic                   IFIDFlush;
    logic                   IDEXWrite;
    logic                   CtrlSel;
    logic                   ExMemCtrlSel;
    logic                   MulBusy;
    logic [STALL_CNT_W-1:0] StallCnt;

    // Datapath side: presents hazard information, consumes enables/selects.
    modport master (
        output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_IsMul,
        output EX_MemRead, EX_Rd, EX_BranchTaken,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite,
        input  CtrlSel, ExMemCtrlSel, MulBusy, StallCnt
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_IsMul,
        input  EX_MemRead, EX_Rd, EX_BranchTaken,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite,
        output CtrlSel, ExMemCtrlSel, MulBusy, StallCnt
    );

endinterface : pipeline_stall_controller_if
`default_nettype wire

// File: rtl/pipeline_stall_controller_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Enabled up-counter that sticks at all-ones; async active-low clear.
// Rev    : 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_en,
    output logic [WIDTH-1:0]      o_cnt
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = &r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en && !w_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module : pipeline_stall_controller
// Brief  : Stall/bubble/flush sequencing for load-use, taken branch and multi-cycle multiply.
// Rev    : 1.0
// ============================================================================
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MUL_LAT     = c_DEF_MUL_LAT,
    parameter int CNT_W       = 3,
    parameter int STALL_CNT_W = 16
) (
    input  wire logic                  Clk,
    input  wire logic                  Rst_n,
    pipeline_stall_controller_if.slave bus
);

    localparam logic             c_MUL_MULTI = (MUL_LAT > 1);
    localparam logic [CNT_W-1:0] c_CNT_LOAD  = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_load_use;
    logic               w_rs_hit;
    logic               w_rt_hit;
    logic               w_pc_write;

    assign w_rs_hit   = bus.ID_UsesRs && (bus.ID_Rs == bus.EX_Rd);
    assign w_rt_hit   = bus.ID_UsesRt && (bus.ID_Rt == bus.EX_Rd);
    assign w_load_use = bus.EX_MemRead && (bus.EX_Rd != '0) && (w_rs_hit || w_rt_hit);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= c_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A taken branch kills the ID instruction, and a load-use stall defers the
    // multiply one cycle, so only an unobstructed multiply starts the wait.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_RUN: begin
                if (!bus.EX_BranchTaken && !w_load_use && bus.ID_IsMul && c_MUL_MULTI) begin
                    w_state_nxt = c_MUL_WAIT;
                    w_cnt_nxt   = c_CNT_LOAD;
                end
            end
            c_MUL_WAIT: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_RUN;
                end
            end
            default: begin
                w_state_nxt = c_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_pc_write       = 1'b1;
        bus.IFIDWrite    = 1'b1;
        bus.IFIDFlush    = 1'b0;
        bus.IDEXWrite    = 1'b1;
        bus.CtrlSel      = 1'b1;
        bus.ExMemCtrlSel = 1'b1;
        bus.MulBusy      = 1'b0;
        if (!Rst_n) begin
            w_pc_write       = 1'b0;
            bus.IFIDWrite    = 1'b0;
            bus.IDEXWrite    = 1'b0;
            bus.CtrlSel      = 1'b0;
            bus.ExMemCtrlSel = 1'b0;
        end else if (r_state == c_MUL_WAIT) begin
            w_pc_write       = 1'b0;
            bus.IFIDWrite    = 1'b0;
            bus.IDEXWrite    = 1'b0;
            bus.ExMemCtrlSel = 1'b0;
            bus.MulBusy      = 1'b1;
        end else if (bus.EX_BranchTaken) begin
            bus.IFIDFlush    = 1'b1;
            bus.CtrlSel      = 1'b0;
        end else if (w_load_use) begin
            w_pc_write       = 1'b0;
            bus.IFIDWrite    = 1'b0;
            bus.CtrlSel      = 1'b0;
        end
    end

    assign bus.PCWrite = w_pc_write;

    // Reset also clears the counter asynchronously, so the enable seen during reset is moot.
    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (Clk),
        .rst_n (Rst_n),
        .i_en  (!w_pc_write),
        .o_cnt (bus.StallCnt)
    );

endmodule : pipeline_stall_controller
`default_nettype wire
